uart_rx_check: RTL and testbench
================================

UART_RX_CHECK -- requirements
Module: uart_rx_check

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, serial bit rate in bit/s.
REQ-003 SHALL derive CPB = CLK_HZ/BIT_RATE (integer division) and HALF = CPB/2; CPB >= 4 required.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 uart_rxd  input  1  serial line (8N1, LSB first, idle high); it is the uart_txd output of the sum/latch transmitter.
REQ-007 uart_rx_en  input  1  receive enable.
REQ-008 uart_rx_valid  output  1  one-cycle pulse, new byte on uart_rx_data.
REQ-009 uart_rx_data  output  8  last correctly framed byte.
REQ-010 uart_rx_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 uart_rx_break  output  1  one-cycle pulse, frame error with all data bits 0.

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rxs.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on rxs==0 and uart_rx_en==1 -> START, clear cycle counter; this cycle is the detection cycle D.
REQ-015 START: at D+HALF sample rxs; 0 -> DATA; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: bit i (i=0..7) sampled at D+HALF+(i+1)*CPB into shift register, LSB first; after bit 7 -> STOP.
REQ-017 STOP: sampled at D+HALF+9*CPB; 1 -> IDLE, uart_rx_data<=shift value, uart_rx_valid=1 the next cycle.
REQ-018 STOP sample 0 -> WAIT_HIGH; uart_rx_frame_err=1 the next cycle; uart_rx_break=1 in the same cycle iff shift value==0x00; uart_rx_data unchanged.
REQ-019 WAIT_HIGH: remain until rxs==1, then IDLE; no new frame detection while in WAIT_HIGH.
REQ-020 Pulses SHALL last exactly one cycle; uart_rx_valid and uart_rx_frame_err never both high.
REQ-021 uart_rx_data SHALL hold its value until the next valid frame.
REQ-022 Back-to-back frames: return to IDLE in the cycle after the stop sample; a start edge arriving from then on SHALL be detected.
REQ-023 uart_rx_en low outside IDLE SHALL abort to IDLE next cycle without output pulses; uart_rx_data unchanged.
REQ-024 Cycle counter width SHALL be clog2(CPB)+1 bits and SHALL not wrap within a bit period.

Reset
REQ-025 reset high SHALL asynchronously force: state IDLE, synchronizer flops 1, counter 0, shift register 0x00, uart_rx_data 0x00, all pulse outputs 0.
REQ-026 reset asserted mid-frame SHALL discard the partial byte; after release the block waits for a new falling edge.

Verification (CLK_HZ=1_000_000, BIT_RATE=100_000 -> CPB=10, HALF=5)
REQ-027 Send 0x3E (31+31) framed 8N1 -> one uart_rx_valid pulse, uart_rx_data=0x3E, no frame_err.
REQ-028 Drive uart_rxd low 3 cycles then high -> no pulse, state returns to IDLE, subsequent 0x05 received correctly.
REQ-029 Send 0xA5 with stop bit 0 -> uart_rx_frame_err pulse, uart_rx_break 0, uart_rx_data keeps prior value; line held low 20 cycles -> no new frame until high.
REQ-030 Send 0x00 with stop bit 0 -> uart_rx_frame_err and uart_rx_break pulse together.
REQ-031 Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-032 Assert reset during bit 4 of 0x3C, release, then send 0x12 -> only one valid, data 0x12; uart_rx_en=0 during a full frame -> no pulses.

Source files
------------

// File: rtl/uart_rx_check_if.sv
// Serial receive bundle: the line and enable going into the receiver, plus the
// decoded byte and its status pulses coming back out.
interface uart_rx_check_if;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_frame_err;
  logic       uart_rx_break;

  modport master (
    output uart_rxd, uart_rx_en,
    input  uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break
  );

  modport slave (
    input  uart_rxd, uart_rx_en,
    output uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break
  );
endinterface

// File: rtl/uart_rx_check.sv
// 8N1 UART receiver with mid-bit sampling, frame-error and break detection,
// and a wait-for-idle-high recovery after a bad stop bit.
module uart_rx_check #(
  parameter int CLK_HZ   = 10_000_000,
  parameter int BIT_RATE = 9600
) (
  input logic            clk,
  input logic            reset,
  uart_rx_check_if.slave rx
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB) + 1;

  // Counter is cleared on the edge that enters a phase, so the sample edge is
  // reached when it shows (distance - 1).
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic [2:0]    state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          break_q;

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would let later lines see new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      rx_meta     <= rx.uart_rxd;
      rxs         <= rx_meta;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;

      // Dropping enable mid-frame abandons the frame silently.
      if (state != IDLE && !rx.uart_rx_en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rxs && rx.uart_rx_en) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == HALF_END) begin
              cnt     <= '0;
              bit_idx <= 3'd0;
              state   <= rxs ? IDLE : DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == BIT_END) begin
              cnt     <= '0;
              shift   <= {rxs, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == BIT_END) begin
              cnt <= '0;
              if (rxs) begin
                data_q  <= shift;
                valid_q <= 1'b1;
                state   <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                break_q     <= (shift == 8'h00);
                state       <= WAIT_HIGH;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_HIGH: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rx.uart_rx_valid     = valid_q;
  assign rx.uart_rx_data      = data_q;
  assign rx.uart_rx_frame_err = frame_err_q;
  assign rx.uart_rx_break     = break_q;

endmodule

// File: tb/tb_uart_rx_check.sv
// Directed bench for uart_rx_check: a line-history model predicts every output
// cycle by cycle, and literal expectations pin the scenario outcomes.
module tb_uart_rx_check;

  localparam int CPB  = 10;
  localparam int HALF = 5;
  localparam int HN   = 4096;

  logic clk = 1'b0;
  logic reset;
  uart_rx_check_if bus();

  uart_rx_check #(.CLK_HZ(1_000_000), .BIT_RATE(100_000)) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the line as seen at every rising edge, and the receiver's expected
  // behaviour derived from the sample-point arithmetic of an 8N1 frame.
  logic       hist [0:HN-1];
  int         cyc = 0;
  int         live_from = 0;
  bit         busy = 0;
  bit         waiting = 0;
  int         d_edge = 0;
  logic       m_valid = 0;
  logic       m_fe = 0;
  logic       m_brk = 0;
  logic [7:0] m_data = 8'h00;

  // Value the receiver logic sees at edge n: the line two edges earlier, or
  // idle-high while the synchronizer is still refilling after reset.
  function automatic logic rxs_at(input int n);
    if (n - 2 < live_from) return 1'b1;
    return hist[(n - 2) % HN];
  endfunction

  always @(posedge clk) begin
    logic [7:0] b;
    hist[cyc % HN] = bus.uart_rxd;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_brk   = 1'b0;
    if (reset) begin
      busy      = 0;
      waiting   = 0;
      m_data    = 8'h00;
      live_from = cyc + 1;
    end else if (!busy) begin
      if (bus.uart_rx_en && !rxs_at(cyc)) begin
        busy   = 1;
        d_edge = cyc;
      end
    end else if (!bus.uart_rx_en) begin
      busy    = 0;
      waiting = 0;
    end else if (waiting) begin
      if (rxs_at(cyc)) begin
        busy    = 0;
        waiting = 0;
      end
    end else if (cyc - d_edge == HALF) begin
      if (rxs_at(cyc)) busy = 0;
    end else if (cyc - d_edge == HALF + 9 * CPB) begin
      for (int i = 0; i < 8; i++) b[i] = rxs_at(d_edge + HALF + (i + 1) * CPB);
      if (rxs_at(cyc)) begin
        m_valid = 1'b1;
        m_data  = b;
        busy    = 0;
      end else begin
        m_fe    = 1'b1;
        m_brk   = (b == 8'h00);
        waiting = 1;
      end
    end
    cyc++;
  end

  // Per-cycle compare plus pulse bookkeeping for the literal checks.
  bit         running = 0;
  int         n_valid = 0;
  int         n_fe = 0;
  int         n_brk = 0;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (running) begin
      if (reset) begin
        check("rst_valid", bus.uart_rx_valid, 0);
        check("rst_fe", bus.uart_rx_frame_err, 0);
        check("rst_brk", bus.uart_rx_break, 0);
        check("rst_data", bus.uart_rx_data, 0);
      end else begin
        check("valid", bus.uart_rx_valid, m_valid);
        check("frame_err", bus.uart_rx_frame_err, m_fe);
        check("break", bus.uart_rx_break, m_brk);
        check("data", bus.uart_rx_data, m_data);
        check("excl", bus.uart_rx_valid & bus.uart_rx_frame_err, 0);
        if (bus.uart_rx_valid === 1'b1) begin
          n_valid++;
          rx_q.push_back(bus.uart_rx_data);
        end
        if (bus.uart_rx_frame_err === 1'b1) n_fe++;
        if (bus.uart_rx_break === 1'b1) n_brk++;
      end
    end
  end

  task automatic drive_bit(input logic v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.uart_rxd = v;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic send_partial(input logic [7:0] b, input int ncycles);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int c = 0; c < ncycles; c++) drive_bit(frame[c / CPB], 1);
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (cycles) @(negedge clk);
    bus.uart_rxd = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.uart_rxd = 1'b1;
    bus.uart_rx_en = 1'b1;
    repeat (3) @(negedge clk);
    running = 1;
    #2 reset = 1'b0;
    drive_bit(1'b1, 5);
    check("reset_data", bus.uart_rx_data, 8'h00);
    check("reset_valid", bus.uart_rx_valid, 1'b0);

    // Good frame.
    send_byte(8'h3E, 1'b1);
    drive_bit(1'b1, 20);
    check("3e_count", n_valid, 1);
    check("3e_data", bus.uart_rx_data, 8'h3E);
    check("3e_model", m_data, 8'h3E);
    check("3e_nofe", n_fe, 0);

    // Short low glitch must be rejected, then a real frame follows.
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20);
    check("glitch_count", n_valid, 1);
    send_byte(8'h05, 1'b1);
    drive_bit(1'b1, 20);
    check("05_count", n_valid, 2);
    check("05_data", bus.uart_rx_data, 8'h05);

    // Bad stop bit, line then held low: no new frame until it rises.
    send_byte(8'hA5, 1'b0);
    drive_bit(1'b0, 20);
    check("a5_fe", n_fe, 1);
    check("a5_brk", n_brk, 0);
    check("a5_hold_valid", n_valid, 2);
    drive_bit(1'b1, 20);
    check("a5_data_kept", bus.uart_rx_data, 8'h05);
    check("a5_after_high", n_valid, 2);

    // Break: all-zero data with a low stop bit.
    send_byte(8'h00, 1'b0);
    drive_bit(1'b1, 20);
    check("brk_fe", n_fe, 2);
    check("brk_brk", n_brk, 1);
    check("brk_data_kept", bus.uart_rx_data, 8'h05);

    // Back-to-back frames with no idle gap.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    drive_bit(1'b1, 20);
    check("b2b_count", n_valid, 4);
    check("b2b_first", rx_q[2], 8'h00);
    check("b2b_second", rx_q[3], 8'hFF);

    // Reset in the middle of bit 4 of 0x3C, then a clean 0x12.
    send_partial(8'h3C, 5 * CPB + HALF);
    pulse_reset(3);
    drive_bit(1'b1, 2);
    check("midrst_data", bus.uart_rx_data, 8'h00);
    drive_bit(1'b1, 20);
    send_byte(8'h12, 1'b1);
    drive_bit(1'b1, 20);
    check("midrst_count", n_valid, 5);
    check("midrst_data12", bus.uart_rx_data, 8'h12);

    // Receiver disabled for a whole frame.
    bus.uart_rx_en = 1'b0;
    send_byte(8'h77, 1'b1);
    drive_bit(1'b1, 5);
    bus.uart_rx_en = 1'b1;
    drive_bit(1'b1, 20);
    check("dis_count", n_valid, 5);
    check("dis_fe", n_fe, 2);
    check("dis_data", bus.uart_rx_data, 8'h12);

    // Enable dropped mid-frame: abort without pulses, line recovers.
    send_partial(8'h81, 3 * CPB);
    bus.uart_rx_en = 1'b0;
    drive_bit(1'b1, 3);
    send_partial(8'h81, 0);
    drive_bit(1'b1, 5 * CPB);
    bus.uart_rx_en = 1'b1;
    drive_bit(1'b1, 20);
    check("abort_count", n_valid, 5);
    check("abort_fe", n_fe, 2);
    send_byte(8'h81, 1'b1);
    drive_bit(1'b1, 20);
    check("81_count", n_valid, 6);
    check("81_data", bus.uart_rx_data, 8'h81);

    running = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
